// File: rtl/mem_access_ctrl_if.sv
// Bus between the multicycle datapath (master) and the memory access sequencer (slave).
// The memory's returned read word rides on the same bundle.
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic              ir_sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, we, ir_sel, addr, wdata, mem_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, ir, mdr, busy, done, err
  );

  modport slave (
    input  req, we, ir_sel, addr, wdata, mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, ir, mdr, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer between the multicycle datapath and the word-addressed data memory:
// one request at a time, fixed-latency strobes, read capture into IR or MDR.
module mem_access_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned LATENCY   = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned LAT_EFF = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned CNT_W   = $clog2(LAT_EFF + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ir_sel_q, ir_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              bad_addr_c;

  assign bad_addr_c = (bus.addr[1:0] != 2'b00) || (bus.addr >= ADDR_LIMIT);

  // Next state, datapath registers, and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ir_sel_d    = ir_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d        = bus.we;
          ir_sel_d    = bus.ir_sel;
          mem_addr_d  = bus.addr;
          mem_wdata_d = bus.wdata;
          err_d       = 1'b0;
          if (bad_addr_c) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(LAT_EFF);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (ir_sel_q) ir_d  = bus.mem_rdata;
            else          mdr_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_read_d  = (state_d == S_ACCESS) && !we_d;
    // Write strobe only in the last access cycle so memory sees a single write edge
    mem_write_d = (state_d == S_ACCESS) && we_d && (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ir_sel_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ir_sel_q    <= ir_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ir        = ir_q;
  assign bus.mdr       = mdr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (LATENCY 1, 3, 4), each with its own
// 32-word memory model; table vectors plus back-to-back and async-reset sequences.
module tb_mem_access_ctrl;

  localparam int NI = 3;

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] req_v, we_v, sel_v;
  logic [31:0]   addr_v  [NI];
  logic [31:0]   wdata_v [NI];
  logic [NI-1:0] rd_v, wr_v, busy_v, done_v, err_v;
  logic [31:0]   ir_v  [NI];
  logic [31:0]   mdr_v [NI];

  for (genvar g = 0; g < NI; g++) begin : u
    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    logic [31:0] mem [32];

    mem_access_ctrl #(
      .DATA_W(32), .ADDR_W(32), .MEM_WORDS(32), .LATENCY(lat_of(g))
    ) dut (
      .clk(clk),
      .reset(rst_n),
      .bus(bus)
    );

    assign bus.req       = req_v[g];
    assign bus.we        = we_v[g];
    assign bus.ir_sel    = sel_v[g];
    assign bus.addr      = addr_v[g];
    assign bus.wdata     = wdata_v[g];
    assign bus.mem_rdata = mem[bus.mem_addr[6:2]];
    assign rd_v[g]   = bus.mem_read;
    assign wr_v[g]   = bus.mem_write;
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign err_v[g]  = bus.err;
    assign ir_v[g]   = bus.ir;
    assign mdr_v[g]  = bus.mdr;

    initial begin
      for (int i = 0; i < 32; i++) mem[i] = {4'(g + 1), 28'(i)};
      if (g == 0) mem[2] = 32'h0123_AEFD;
    end

    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
    int          rd;
    int          wr;
    int          lat;
  } vec_t;
  vec_t vt[10];

  // Pops one expectation when done is seen and compares the result registers
  task automatic sb_check(input int inst, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_err"}, 32'(err_v[inst]), 32'(e.err));
    chk({tag, "_ir"},  ir_v[inst],  e.ir);
    chk({tag, "_mdr"}, mdr_v[inst], e.mdr);
  endtask

  task automatic do_req(input int inst, input vec_t v, input string tag);
    int k, rdc, wrc;
    logic got;
    sb.push_back('{v.err, v.ir, v.mdr});
    @(negedge clk);
    req_v[inst] = 1'b1; we_v[inst] = v.we; sel_v[inst] = v.sel;
    addr_v[inst] = v.addr; wdata_v[inst] = v.wdata;
    k = 0; rdc = 0; wrc = 0; got = 1'b0;
    while (k < 30 && !got) begin
      @(negedge clk);
      req_v[inst] = 1'b0;
      k++;
      rdc += int'(rd_v[inst]);
      wrc += int'(wr_v[inst]);
      if (done_v[inst]) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      chk({tag, "_done_lat"}, 32'(k), 32'(v.lat));
      sb_check(inst, tag);
    end
    chk({tag, "_rd_cycles"}, 32'(rdc), 32'(v.rd));
    chk({tag, "_wr_cycles"}, 32'(wrc), 32'(v.wr));
  endtask

  initial begin
    int nd, idle_s, rdc;
    int done_s[2];
    logic second_set, dropped;

    req_v = '0; we_v = '0; sel_v = '0;
    for (int i = 0; i < NI; i++) begin addr_v[i] = '0; wdata_v[i] = '0; end

    vt[0] = '{1'b0, 1'b1, 32'h08, 32'h0,         1'b0, 32'h0123_AEFD, 32'h0,         1, 0, 2};
    vt[1] = '{1'b1, 1'b0, 32'h04, 32'hABCD_DCBA, 1'b0, 32'h0123_AEFD, 32'h0,         0, 1, 2};
    vt[2] = '{1'b0, 1'b0, 32'h04, 32'h0,         1'b0, 32'h0123_AEFD, 32'hABCD_DCBA, 1, 0, 2};
    vt[3] = '{1'b0, 1'b0, 32'h06, 32'h0,         1'b1, 32'h0123_AEFD, 32'hABCD_DCBA, 0, 0, 1};
    vt[4] = '{1'b0, 1'b0, 32'h7C, 32'h0,         1'b0, 32'h0123_AEFD, 32'h1000_001F, 1, 0, 2};
    vt[5] = '{1'b0, 1'b1, 32'h80, 32'h0,         1'b1, 32'h0123_AEFD, 32'h1000_001F, 0, 0, 1};
    vt[6] = '{1'b1, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b1, 32'h0123_AEFD, 32'h1000_001F, 0, 0, 1};
    vt[7] = '{1'b1, 1'b0, 32'h01, 32'hDEAD_BEEF, 1'b1, 32'h0123_AEFD, 32'h1000_001F, 0, 0, 1};
    vt[8] = '{1'b0, 1'b1, 32'h00, 32'h0,         1'b0, 32'h1000_0000, 32'h1000_001F, 1, 0, 2};
    vt[9] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,  1'b1, 32'h1000_0000, 32'h1000_001F, 0, 0, 1};

    // Power-on reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_err",  32'(err_v),  32'd0);
    chk("rst_ir0",  ir_v[0],  32'd0);
    chk("rst_mdr0", mdr_v[0], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_req(0, vt[i], $sformatf("vec%0d", i));

    // err persists through idle, memory untouched by errored writes
    repeat (3) @(negedge clk);
    chk("err_hold", 32'(err_v[0]), 32'd1);
    chk("idle_busy", 32'(busy_v[0]), 32'd0);
    chk("mem_word1", u[0].mem[1], 32'hABCD_DCBA);
    chk("mem_word0", u[0].mem[0], 32'h1000_0000);
    chk("mem_addr_hold", u[0].bus.mem_addr, 32'hFFFF_FFFC);

    // Back-to-back reads with req held high, LATENCY=4
    sb.push_back('{1'b0, 32'h0, 32'h3000_0004});
    sb.push_back('{1'b0, 32'h3000_0005, 32'h3000_0004});
    @(negedge clk);
    req_v[2] = 1'b1; we_v[2] = 1'b0; sel_v[2] = 1'b0; addr_v[2] = 32'h10;
    nd = 0; idle_s = 0; rdc = 0; second_set = 1'b0; dropped = 1'b0;
    done_s[0] = 0; done_s[1] = 0;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      rdc += int'(rd_v[2]);
      if (done_v[2]) begin
        if (nd < 2) done_s[nd] = s;
        nd++;
        sb_check(2, $sformatf("b2b%0d", nd));
      end
      if (!busy_v[2] && !second_set) begin
        second_set = 1'b1; idle_s = s;
        sel_v[2] = 1'b1; addr_v[2] = 32'h14;
      end else if (second_set && busy_v[2] && !dropped) begin
        dropped = 1'b1; req_v[2] = 1'b0;
      end
    end
    req_v[2] = 1'b0;
    chk("b2b_ndone", 32'(nd), 32'd2);
    chk("b2b_done0", 32'(done_s[0]), 32'd5);
    chk("b2b_idle",  32'(idle_s), 32'd6);
    chk("b2b_done1", 32'(done_s[1]), 32'd11);
    chk("b2b_rd_cycles", 32'(rdc), 32'd8);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // Async reset in the middle of a LATENCY=3 write
    do_req(1, '{1'b0, 1'b1, 32'h08, 32'h0, 1'b0, 32'h2000_0002, 32'h0, 3, 0, 4}, "l3_fetch");
    do_req(1, '{1'b0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h2000_0002, 32'h2000_0003, 3, 0, 4}, "l3_read");
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; sel_v[1] = 1'b0;
    addr_v[1] = 32'h0C; wdata_v[1] = 32'h5555_AAAA;
    @(negedge clk);
    req_v[1] = 1'b0;
    chk("l3_wr_early", 32'(wr_v[1]), 32'd0);
    repeat (2) @(negedge clk);
    chk("l3_wr_final", 32'(wr_v[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr",   32'(wr_v[1]),   32'd0);
    chk("arst_busy", 32'(busy_v[1]), 32'd0);
    chk("arst_done", 32'(done_v[1]), 32'd0);
    chk("arst_ir",   ir_v[1],  32'd0);
    chk("arst_mdr",  mdr_v[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("arst_mem", u[1].mem[3], 32'h2000_0003);
    @(negedge clk);
    chk("arst_idle", 32'(busy_v[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
